// File: rtl/re_tq_pkg.sv
// Shared definitions for the rec_tq input distributor: transform sizes,
// beats-per-block constants and the natural-to-butterfly lane mapping.
package re_tq_pkg;

   localparam int DW    = 28;
   localparam int LANES = 32;

   typedef enum logic [1:0] {
      TS_4  = 2'd0,
      TS_8  = 2'd1,
      TS_16 = 2'd2,
      TS_32 = 2'd3
   } transize_e;

   localparam int BPB_4  = 1;
   localparam int BPB_8  = 2;
   localparam int BPB_16 = 8;
   localparam int BPB_32 = 32;

   function automatic logic [4:0] last_beat(input logic [1:0] ts);
      case (ts)
         TS_4:    return 5'(BPB_4 - 1);
         TS_8:    return 5'(BPB_8 - 1);
         TS_16:   return 5'(BPB_16 - 1);
         default: return 5'(BPB_32 - 1);
      endcase
   endfunction

   // Only 4x4 leaves output lanes undriven: levels 1-3 do not exist there.
   function automatic logic lane_vld(input logic [1:0] ts, input int m);
      return (ts != TS_4) || (m < 16);
   endfunction

   // Natural-order source lane feeding butterfly-order output lane m.
   function automatic logic [4:0] lane_idx(input logic [1:0] ts, input int m);
      int s;
      s = 0;
      case (ts)
         TS_4: s = (m / 4) * 8 + (m % 4);
         TS_8: begin
            if (m < 16) s = (m / 4) * 8 + 4 + (m % 4);
            else        s = ((m - 16) / 4) * 8 + (m % 4);
         end
         TS_16: begin
            if (m < 16)      s = (m / 8) * 16 + 8 + (m % 8);
            else if (m < 24) s = ((m - 16) / 4) * 16 + 4 + (m % 4);
            else             s = ((m - 24) / 4) * 16 + (m % 4);
         end
         default: begin
            if (m < 16)      s = m + 16;
            else if (m < 24) s = m - 8;
            else if (m < 28) s = m - 20;
            else             s = m - 28;
         end
      endcase
      return 5'(s);
   endfunction

endpackage

// File: rtl/re_in_ctl_if.sv
// Beat handshake bundle between the upstream source, re_in_ctl and the
// downstream transform datapath.
interface re_in_ctl_if
   import re_tq_pkg::*;
#(
   parameter int DW = re_tq_pkg::DW
);
   logic                  i_valid;
   logic                  i_ready;
   logic [1:0]            i_transize;
   logic [1:0]            tq_sel_i;
   logic [DW*LANES-1:0]   i_data;
   logic                  o_valid;
   logic                  o_ready;
   logic [DW*LANES-1:0]   o_data;
   logic [1:0]            o_transize;
   logic [1:0]            o_tq_sel;
   logic                  o_sob;
   logic                  o_eob;
   logic                  o_err;

   modport master (
      output i_valid, i_transize, tq_sel_i, i_data, o_ready,
      input  i_ready, o_valid, o_data, o_transize, o_tq_sel, o_sob, o_eob, o_err
   );

   modport slave (
      input  i_valid, i_transize, tq_sel_i, i_data, o_ready,
      output i_ready, o_valid, o_data, o_transize, o_tq_sel, o_sob, o_eob, o_err
   );
endinterface

// File: rtl/re_in_lane_map.sv
// Combinational lane permutation from natural row order into butterfly
// level order; lanes with no source are driven to zero.
module re_in_lane_map
   import re_tq_pkg::*;
#(
   parameter int DW = re_tq_pkg::DW
) (
   input  logic [1:0]          i_transize,
   input  logic [DW*LANES-1:0] i_data,
   output logic [DW*LANES-1:0] o_data
);

   always_comb begin
      o_data = '0;
      for (int m = 0; m < LANES; m++) begin
         if (lane_vld(i_transize, m))
            o_data[DW*m +: DW] = i_data[DW*int'(lane_idx(i_transize, m)) +: DW];
      end
   end

endmodule

// File: rtl/re_in_ctl.sv
// Input lane distributor: re-orders each beat into butterfly level order,
// registers it behind a one-deep valid/ready stage and tags block boundaries.
module re_in_ctl
   import re_tq_pkg::*;
#(
   parameter int DW = re_tq_pkg::DW
) (
   input logic        clk,
   input logic        rst,
   re_in_ctl_if.slave bus
);

   logic [4:0]          cnt;
   logic [1:0]          lock_ts;
   logic [1:0]          lock_tq;
   logic                accept;
   logic                first;
   logic                last;
   logic [1:0]          ts_use;
   logic [1:0]          tq_use;
   logic [DW*LANES-1:0] mapped;

   assign bus.i_ready = !bus.o_valid || bus.o_ready;
   assign accept      = bus.i_valid && bus.i_ready;

   // The first beat of a block uses the live size/select; later beats use the lock.
   assign first  = (cnt == 5'd0);
   assign ts_use = first ? bus.i_transize : lock_ts;
   assign tq_use = first ? bus.tq_sel_i   : lock_tq;
   assign last   = (cnt == last_beat(ts_use));

   re_in_lane_map #(.DW(DW)) u_map (
      .i_transize (ts_use),
      .i_data     (bus.i_data),
      .o_data     (mapped)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.o_valid    <= 1'b0;
         bus.o_data     <= '0;
         bus.o_transize <= 2'd0;
         bus.o_tq_sel   <= 2'd0;
         bus.o_sob      <= 1'b0;
         bus.o_eob      <= 1'b0;
         bus.o_err      <= 1'b0;
         cnt            <= 5'd0;
         lock_ts        <= 2'd0;
         lock_tq        <= 2'd0;
      end else if (accept) begin
         bus.o_valid    <= 1'b1;
         bus.o_data     <= mapped;
         bus.o_transize <= ts_use;
         bus.o_tq_sel   <= tq_use;
         bus.o_sob      <= first;
         bus.o_eob      <= last;
         bus.o_err      <= !first && (bus.i_transize != lock_ts);
         cnt            <= last ? 5'd0 : cnt + 5'd1;
         if (first) begin
            lock_ts <= bus.i_transize;
            lock_tq <= bus.tq_sel_i;
         end
      end else if (bus.o_ready) begin
         // Beat consumed with nothing behind it; err is a per-beat pulse.
         bus.o_valid <= 1'b0;
         bus.o_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_re_in_ctl.sv
// Directed and randomised checks of re_in_ctl: lane mapping, block tags,
// size locking, stall behaviour and round trip through the output reorder.
module tb_re_in_ctl;
   import re_tq_pkg::*;

   localparam int W = DW * LANES;
   typedef logic [W-1:0] beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   re_in_ctl_if #(.DW(DW)) bus ();
   re_in_ctl #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct { int ts; int olo; int ilo; int len; } seg_t;
   seg_t segs[22];

   typedef struct { logic [1:0] ts; int lane; int val; } vec_t;
   vec_t vecs[17];

   typedef struct { beat_t din; logic [1:0] ts; logic [1:0] tq; logic sob; logic eob; } exp_t;
   exp_t q[$];

   bit         mon_en = 1'b0;
   int         mcnt   = 0;
   logic [1:0] mts, mtq;
   int         pushes = 0;
   int         pops   = 0;
   logic       ov_before;

   function automatic logic [DW-1:0] lane(input beat_t d, input int k);
      return d[DW*k +: DW];
   endfunction

   function automatic beat_t mk(input int base);
      beat_t r;
      for (int k = 0; k < LANES; k++) r[DW*k +: DW] = DW'(base + k);
      return r;
   endfunction

   function automatic beat_t rnd_beat();
      beat_t r;
      for (int k = 0; k < LANES; k++) r[DW*k +: DW] = DW'($urandom);
      return r;
   endfunction

   function automatic beat_t fwd(input logic [1:0] ts, input beat_t d);
      beat_t r = '0;
      for (int s = 0; s < 22; s++)
         if (segs[s].ts == int'(ts))
            for (int i = 0; i < segs[s].len; i++)
               r[DW*(segs[s].olo+i) +: DW] = d[DW*(segs[s].ilo+i) +: DW];
      return r;
   endfunction

   // Output reorder stage: the inverse permutation.
   function automatic beat_t rev(input logic [1:0] ts, input beat_t o);
      beat_t r = '0;
      for (int s = 0; s < 22; s++)
         if (segs[s].ts == int'(ts))
            for (int i = 0; i < segs[s].len; i++)
               r[DW*(segs[s].ilo+i) +: DW] = o[DW*(segs[s].olo+i) +: DW];
      return r;
   endfunction

   function automatic beat_t keep(input logic [1:0] ts, input beat_t d);
      beat_t r = d;
      if (ts == 2'd0)
         for (int k = 0; k < LANES; k++)
            if ((k % 8) >= 4) r[DW*k +: DW] = '0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
      bit done;
      total++;
      if (act !== exp) begin
         bad++;
         done = 1'b0;
         for (int k = 0; k < LANES; k++)
            if (!done && (lane(act, k) !== lane(exp, k))) begin
               $display("FAIL %s: lane %0d got %0h want %0h", name, k, lane(act, k), lane(exp, k));
               done = 1'b1;
            end
      end
   endtask

   task automatic send(input logic [1:0] ts, input logic [1:0] tq, input beat_t d);
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.i_valid    = 1'b1;
      bus.i_transize = ts;
      bus.tq_sel_i   = tq;
      bus.i_data     = d;
      @(negedge clk);
      while (!bus.i_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
      ov_before = bus.o_valid;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.o_valid && bus.o_ready) begin
            if (q.size() == 0) begin
               chk("rnd_unexpected_beat", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               pops++;
               chk_beat("rnd_roundtrip", rev(e.ts, bus.o_data), keep(e.ts, e.din));
               chk("rnd_tags", {25'd0, bus.o_transize, bus.o_tq_sel, bus.o_sob, bus.o_eob, bus.o_err},
                   {25'd0, e.ts, e.tq, e.sob, e.eob, 1'b0});
            end
         end
         if (bus.i_valid && bus.i_ready) begin
            logic f, l;
            int bpb;
            f = (mcnt == 0);
            if (f) begin
               mts = bus.i_transize;
               mtq = bus.tq_sel_i;
            end
            bpb = (mts == 2'd0) ? 1 : (mts == 2'd1) ? 2 : (mts == 2'd2) ? 8 : 32;
            l = (mcnt == bpb - 1);
            q.push_back('{bus.i_data, mts, mtq, f, l});
            pushes++;
            mcnt = l ? 0 : mcnt + 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t d0, d1, d;
      int nb, sent;
      logic [1:0] ts, tq;
      bit done;

      segs[0]  = '{0, 0, 0, 4};   segs[1]  = '{0, 4, 8, 4};
      segs[2]  = '{0, 8, 16, 4};  segs[3]  = '{0, 12, 24, 4};
      segs[4]  = '{1, 16, 0, 4};  segs[5]  = '{1, 0, 4, 4};
      segs[6]  = '{1, 20, 8, 4};  segs[7]  = '{1, 4, 12, 4};
      segs[8]  = '{1, 24, 16, 4}; segs[9]  = '{1, 8, 20, 4};
      segs[10] = '{1, 28, 24, 4}; segs[11] = '{1, 12, 28, 4};
      segs[12] = '{2, 24, 0, 4};  segs[13] = '{2, 16, 4, 4};
      segs[14] = '{2, 0, 8, 8};   segs[15] = '{2, 28, 16, 4};
      segs[16] = '{2, 20, 20, 4}; segs[17] = '{2, 8, 24, 8};
      segs[18] = '{3, 28, 0, 4};  segs[19] = '{3, 24, 4, 4};
      segs[20] = '{3, 16, 8, 8};  segs[21] = '{3, 0, 16, 16};

      // Input lane k carries k+1; value shows which input lane landed there.
      vecs[0]  = '{2'd0, 0, 1};   vecs[1]  = '{2'd0, 4, 9};
      vecs[2]  = '{2'd0, 15, 28}; vecs[3]  = '{2'd0, 16, 0};
      vecs[4]  = '{2'd1, 0, 5};   vecs[5]  = '{2'd1, 16, 1};
      vecs[6]  = '{2'd1, 12, 29}; vecs[7]  = '{2'd1, 31, 28};
      vecs[8]  = '{2'd2, 0, 9};   vecs[9]  = '{2'd2, 16, 5};
      vecs[10] = '{2'd2, 24, 1};  vecs[11] = '{2'd2, 28, 17};
      vecs[12] = '{2'd2, 15, 32}; vecs[13] = '{2'd3, 0, 17};
      vecs[14] = '{2'd3, 28, 1};  vecs[15] = '{2'd3, 24, 5};
      vecs[16] = '{2'd3, 16, 9};

      rst = 1'b1;
      bus.i_valid = 1'b0; bus.i_transize = 2'd0; bus.tq_sel_i = 2'd0;
      bus.i_data = '0; bus.o_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
      chk_beat("rst_o_data", bus.o_data, '0);
      chk("rst_tags", {27'd0, bus.o_transize, bus.o_tq_sel, bus.o_sob, bus.o_eob, bus.o_err}, 32'd0);
      chk("rst_i_ready", 32'(bus.i_ready), 32'd1);

      // size0 single beat, latency
      send(2'd0, 2'd0, mk(1));
      chk("s0_valid_before", 32'(ov_before), 32'd0);
      @(negedge clk);
      chk("s0_valid_after", 32'(bus.o_valid), 32'd1);
      chk_beat("s0_data", bus.o_data, fwd(2'd0, mk(1)));
      chk("s0_sob_eob", {30'd0, bus.o_sob, bus.o_eob}, 32'd3);
      @(negedge clk);
      chk("s0_valid_drop", 32'(bus.o_valid), 32'd0);

      for (int i = 0; i < 17; i++) begin
         do_reset();
         send(vecs[i].ts, 2'd0, mk(1));
         @(negedge clk);
         chk($sformatf("vec%0d_lane%0d", i, vecs[i].lane), 32'(lane(bus.o_data, vecs[i].lane)), 32'(vecs[i].val));
         chk($sformatf("vec%0d_sob_eob", i), {30'd0, bus.o_sob, bus.o_eob}, {30'd0, 1'b1, vecs[i].ts == 2'd0});
      end

      // reset mid-block
      do_reset();
      for (int b = 0; b < 5; b++) send(2'd3, 2'd3, mk(50*b + 7));
      do_reset();
      @(negedge clk);
      chk("midrst_o_valid", 32'(bus.o_valid), 32'd0);
      chk_beat("midrst_o_data", bus.o_data, '0);
      chk("midrst_tags", {27'd0, bus.o_transize, bus.o_tq_sel, bus.o_sob, bus.o_eob, bus.o_err}, 32'd0);
      send(2'd1, 2'd1, mk(3));
      @(negedge clk);
      chk("midrst_restart", {28'd0, bus.o_transize, bus.o_sob, bus.o_eob}, {28'd0, 2'd1, 1'b1, 1'b0});
      send(2'd1, 2'd0, mk(4));
      @(negedge clk);
      chk("midrst_end", {28'd0, bus.o_tq_sel, bus.o_sob, bus.o_eob}, {28'd0, 2'd1, 1'b0, 1'b1});

      // size3 full block then a new block
      for (int b = 0; b < 32; b++) begin
         send(2'd3, 2'd2, mk(100*b));
         @(negedge clk);
         chk($sformatf("s3_b%0d_tags", b), {28'd0, bus.o_transize, bus.o_sob, bus.o_eob},
             {28'd0, 2'd3, b == 0, b == 31});
         chk($sformatf("s3_b%0d_lanes", b), {4'd0, lane(bus.o_data, 0)} + 32'(lane(bus.o_data, 28)) * 32'd65536,
             32'(100*b + 16) + 32'(100*b) * 32'd65536);
      end
      send(2'd0, 2'd1, mk(5));
      @(negedge clk);
      chk("s3_next_sob", {30'd0, bus.o_sob, bus.o_eob}, 32'd3);

      // size1 with downstream stall
      d0 = mk(200);
      d1 = mk(300);
      @(posedge clk); #1;
      bus.o_ready = 1'b0;
      send(2'd1, 2'd2, d0);
      bus.i_valid = 1'b1; bus.i_transize = 2'd1; bus.tq_sel_i = 2'd2; bus.i_data = d1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_ready_valid", c), {30'd0, bus.i_ready, bus.o_valid}, 32'd1);
         chk_beat($sformatf("stall%0d_data", c), bus.o_data, fwd(2'd1, d0));
         chk($sformatf("stall%0d_sob_eob", c), {30'd0, bus.o_sob, bus.o_eob}, 32'd2);
      end
      @(posedge clk); #1;
      bus.o_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_ready", 32'(bus.i_ready), 32'd1);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      chk("stall_b1_tags", {30'd0, bus.o_valid, bus.o_sob, bus.o_eob}, 32'd5);
      chk_beat("stall_b1_data", bus.o_data, fwd(2'd1, d1));
      @(negedge clk);
      chk("stall_no_dup", 32'(bus.o_valid), 32'd0);

      // size2 with a size change on beat 3
      for (int b = 0; b < 8; b++) begin
         d = mk(1000*b);
         send((b == 3) ? 2'd1 : 2'd2, 2'd1, d);
         @(negedge clk);
         chk($sformatf("err_b%0d_tags", b), {27'd0, bus.o_transize, bus.o_sob, bus.o_eob, bus.o_err},
             {27'd0, 2'd2, b == 0, b == 7, b == 3});
         chk_beat($sformatf("err_b%0d_data", b), bus.o_data, fwd(2'd2, d));
      end

      // random sizes, data and back-pressure through the reorder stage
      sent = 0;
      done = 1'b0;
      mcnt = 0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      fork
         begin
            for (int blk = 0; blk < 12; blk++) begin
               ts = (blk < 4) ? 2'(blk) : 2'($urandom_range(0, 3));
               tq = 2'($urandom_range(0, 3));
               nb = (ts == 2'd0) ? 1 : (ts == 2'd1) ? 2 : (ts == 2'd2) ? 8 : 32;
               for (int b = 0; b < nb; b++) begin
                  repeat ($urandom_range(0, 2)) @(posedge clk);
                  send(ts, (b == 0) ? tq : 2'($urandom_range(0, 3)), rnd_beat());
                  sent++;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.o_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      @(posedge clk); #1;
      bus.o_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1 mon_en = 1'b0;
      chk("rnd_queue_empty", 32'(q.size()), 32'd0);
      chk("rnd_pushes", 32'(pushes), 32'(sent));
      chk("rnd_pops", 32'(pops), 32'(sent));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
